// File: rtl/core_featuremap_column_packer_if.sv
// Upstream-read / downstream-write FIFO handshake bundle for the column packer.
// The packer is the master; the surrounding FIFOs (or a bench) form the slave side.
interface core_featuremap_column_packer_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0]   ff_rdata;
    logic                ff_rdreq;
    logic                ff_empty;
    logic [3*DWIDTH-1:0] ff_wdata;
    logic                ff_wrreq;
    logic                ff_full;

    modport master (
        input  ff_rdata, ff_empty, ff_full,
        output ff_rdreq, ff_wdata, ff_wrreq
    );

    modport slave (
        output ff_rdata, ff_empty, ff_full,
        input  ff_rdreq, ff_wdata, ff_wrreq
    );
endinterface

// File: rtl/core_featuremap_column_packer.sv
// Keeps the two previous image rows in line buffers and, from row 2 onward, emits one
// packed vertical triple {row r-2, row r-1, row r} per column through a 2-entry skid buffer.
module core_featuremap_column_packer #(
    parameter int DWIDTH     = 32,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input logic clock,
    input logic reset,
    core_featuremap_column_packer_if.master fm
);
    localparam int CW = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = $clog2(IMG_HEIGHT);

    typedef struct packed {
        logic [DWIDTH-1:0] top;
        logic [DWIDTH-1:0] mid;
        logic [DWIDTH-1:0] bot;
    } triple_t;

    typedef enum logic {FILL, STREAM} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          rd_en;
    logic          rd_vld;

    logic [DWIDTH-1:0] lb0 [IMG_WIDTH];
    logic [DWIDTH-1:0] lb1 [IMG_WIDTH];

    triple_t    obuf [2];
    logic       obuf_head;
    logic [1:0] obuf_cnt;

    logic       col_last;
    logic       row_last;
    logic       push;
    logic       pop;
    logic       rd_room;
    logic [2:0] occ_nxt;
    triple_t    cap_triple;

    assign col_last   = (col == CW'(IMG_WIDTH - 1));
    assign row_last   = (row == RW'(IMG_HEIGHT - 1));
    assign push       = rd_vld && (state == STREAM);
    assign pop        = (obuf_cnt != 2'd0) && !fm.ff_full;
    assign cap_triple = {lb0[col], lb1[col], fm.ff_rdata};

    // Mode changes only on the last column's capture; the new mode governs the next capture.
    always_comb begin
        state_nxt = state;
        if (rd_vld && col_last) begin
            if (state == FILL && row == RW'(1))
                state_nxt = STREAM;
            else if (state == STREAM && row_last)
                state_nxt = FILL;
        end
    end

    // A read issued now is captured under state_nxt; only emitting captures need a free slot.
    assign occ_nxt = {1'b0, obuf_cnt} + {2'b00, push} - {2'b00, pop};
    assign rd_room = (state_nxt == FILL) || (occ_nxt < 3'd2);

    assign fm.ff_rdreq = rd_en && !fm.ff_empty && rd_room;
    assign fm.ff_wrreq = pop;
    assign fm.ff_wdata = obuf[obuf_head];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= FILL;
            col       <= '0;
            row       <= '0;
            rd_en     <= 1'b0;
            rd_vld    <= 1'b0;
            obuf[0]   <= '0;
            obuf[1]   <= '0;
            obuf_head <= 1'b0;
            obuf_cnt  <= 2'd0;
        end else begin
            rd_en  <= 1'b1;
            rd_vld <= fm.ff_rdreq;
            state  <= state_nxt;
            if (rd_vld) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            // Tail slot is head when empty, the other slot when one entry is held.
            if (push)
                obuf[obuf_head ^ obuf_cnt[0]] <= cap_triple;
            if (pop)
                obuf_head <= ~obuf_head;
            obuf_cnt <= obuf_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Line buffers carry no reset: the two FILL rows overwrite every column before use.
    always_ff @(posedge clock) begin
        if (rd_vld) begin
            lb0[col] <= lb1[col];
            lb1[col] <= fm.ff_rdata;
        end
    end
endmodule

// File: tb/tb_core_featuremap_column_packer.sv
// Drives pixel frames through the column packer and checks every written triple
// against a position-based reference model of the vertical 3-row window.
module tb_core_featuremap_column_packer;
    localparam int DW = 32;
    localparam int W  = 4;
    localparam int H  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    core_featuremap_column_packer_if #(.DWIDTH(DW)) fm ();

    core_featuremap_column_packer #(
        .DWIDTH    (DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clock(clock),
        .reset(reset),
        .fm   (fm)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0]   src_q [$];
    logic [3*DW-1:0] exp_q [$];
    logic [DW-1:0]   hist [H][W];
    int              pos = 0;
    logic [3*DW-1:0] first_w;
    logic [3*DW-1:0] last_w;

    task automatic chk(input string tag, input logic [3*DW-1:0] obs, input logic [3*DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: pixel k since reset sits at (k/W mod H, k mod W); rows >= 2 yield a triple
    // from the latest pixels seen at the same column two rows and one row above.
    task automatic feed(input logic [DW-1:0] px);
        int r;
        int c;
        r = (pos / W) % H;
        c = pos % W;
        if (r >= 2)
            exp_q.push_back({hist[r-2][c], hist[r-1][c], px});
        hist[r][c] = px;
        src_q.push_back(px);
        pos++;
    endtask

    task automatic feed_frame(input bit seq);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                feed(seq ? DW'(r * 16 + c) : DW'($urandom()));
    endtask

    task automatic reset_dut();
        @(posedge clock);
        #1;
        reset = 1'b0;
        fm.ff_empty = 1'b0;
        fm.ff_full  = 1'b0;
        src_q.delete();
        exp_q.delete();
        pos = 0;
        repeat (3) begin
            @(negedge clock);
            chk("rst_rdreq", fm.ff_rdreq, 0);
            chk("rst_wrreq", fm.ff_wrreq, 0);
            chk("rst_wdata", fm.ff_wdata, 0);
        end
        @(posedge clock);
        #1;
        fm.ff_empty = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // mode 0: free-running, 1: 10-cycle full burst after first emitting capture,
    // 2: empty toggles each cycle, 3: random empty/full.  drain=0 stops after the last capture.
    task automatic run(input int mode, input bit drain, output int writes, output int lat);
        int budget, tail, caps, first_rd, first_wr, wc, full_left;
        bit rd_now, rd_prev, tog;
        budget = 0; tail = 0; caps = 0; first_rd = -1; first_wr = -1;
        wc = 0; full_left = 0; rd_prev = 1'b0; tog = 1'b0; writes = 0;
        fm.ff_full  = 1'b0;
        fm.ff_empty = (src_q.size() == 0);
        while (budget < 3000 && tail < (drain ? 6 : 1)) begin
            @(negedge clock);
            if (fm.ff_empty) chk("rdreq_while_empty", fm.ff_rdreq, 0);
            if (fm.ff_full)  chk("wrreq_while_full", fm.ff_wrreq, 0);
            if (mode == 1 && fm.ff_full && wc == 10) begin
                chk("rdreq_after_backpressure", fm.ff_rdreq, 0);
                chk("skid_holds_le2", ((caps - 2 * W - writes) <= 2), 1);
            end
            if (fm.ff_wrreq) begin
                if (first_wr < 0) first_wr = budget;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", fm.ff_wrreq, 0);
                end else begin
                    if (writes == 0) first_w = fm.ff_wdata;
                    last_w = fm.ff_wdata;
                    chk("triple", fm.ff_wdata, exp_q.pop_front());
                end
                writes++;
            end
            rd_now = fm.ff_rdreq;
            if (rd_now && first_rd < 0) first_rd = budget;
            @(posedge clock);
            #1;
            if (rd_prev) caps++;
            fm.ff_rdata = (rd_now && src_q.size() > 0) ? src_q.pop_front() : DW'($urandom());
            rd_prev = rd_now;
            if (mode == 1 && wc == 0 && caps == 2 * W + 1) full_left = 10;
            fm.ff_full = (full_left > 0) || (mode == 3 && $urandom_range(3) == 0);
            if (full_left > 0) begin
                full_left--;
                wc++;
            end
            tog = ~tog;
            fm.ff_empty = (src_q.size() == 0) || (mode == 2 && tog) ||
                          (mode == 3 && $urandom_range(2) == 0);
            budget++;
            if (src_q.size() == 0 && !rd_prev && (!drain || exp_q.size() == 0)) tail++;
        end
        fm.ff_empty = 1'b1;
        fm.ff_full  = 1'b0;
        if (drain) chk("all_triples_written", exp_q.size(), 0);
        lat = first_wr - first_rd;
    endtask

    initial begin
        int wr;
        int lat;
        fm.ff_rdata = '0;
        fm.ff_empty = 1'b1;
        fm.ff_full  = 1'b0;
        reset_dut();

        feed_frame(1);
        run(0, 1, wr, lat);
        chk("f1_writes", wr, 8);
        chk("f1_first_latency", lat, 10);
        chk("f1_first_triple", first_w, {32'h00, 32'h10, 32'h20});
        chk("f1_last_triple", last_w, {32'h13, 32'h23, 32'h33});

        feed_frame(1);
        run(1, 1, wr, lat);
        chk("backpressure_writes", wr, 8);

        feed_frame(1);
        run(2, 1, wr, lat);
        chk("starvation_writes", wr, 8);
        chk("starvation_last", last_w, {32'h13, 32'h23, 32'h33});

        feed_frame(1);
        feed_frame(1);
        run(0, 1, wr, lat);
        chk("b2b_writes", wr, 16);

        repeat (3) feed_frame(0);
        run(3, 1, wr, lat);
        chk("random_writes", wr, 24);

        for (int i = 0; i < 11; i++) feed(DW'($urandom()));
        run(0, 0, wr, lat);
        reset_dut();
        feed_frame(1);
        run(0, 1, wr, lat);
        chk("post_reset_writes", wr, 8);
        chk("post_reset_first", first_w, {32'h00, 32'h10, 32'h20});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/core_featuremap_column_packer.md
# core_featuremap_column_packer

Producer-side feeder for the 3-row convolution cores. Consumes a row-major pixel stream of single `DWIDTH` words from an upstream FIFO and keeps the two previous image rows in internal line buffers. From image row 2 onward, it writes one packed vertical triple {row r-2, row r-1, row r} per column into the downstream FIFO. That FIFO is the one the `featuremap_conv2d_*` filter cores read through their `DWIDTH*3` FIFO-read port.

## Interface
- `DWIDTH`, 32, pixel word width.
- `IMG_WIDTH`, 32, pixels per row (≥ 2).
- `IMG_HEIGHT`, 32, rows per frame (≥ 3).
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `ff_rdata`  in  DWIDTH  upstream FIFO read data; valid the cycle after `ff_rdreq` (non-show-ahead).
- `ff_rdreq`  out  1  upstream FIFO read request.
- `ff_empty`  in  1  upstream FIFO empty.
- `ff_wdata`  out  DWIDTH*3  packed triple: [3D-1:2D] row r-2, [2D-1:D] row r-1, [D-1:0] row r.
- `ff_wrreq`  out  1  downstream FIFO write request.
- `ff_full`  in  1  downstream FIFO full.

## Operation
- Line buffers `lb0`, `lb1`: IMG_WIDTH words each. They are not reset, because FILL overwrites them before use.
- Counters: `col` (0..IMG_WIDTH-1) and `row` (0..IMG_HEIGHT-1). Both advance on every captured pixel.
- Capture happens in the cycle after an issued `ff_rdreq`. On capture:
  - `lb0[col] <= lb1[col]`
  - `lb1[col] <= ff_rdata`
  - In STREAM only, push {`lb0[col]`, `lb1[col]`, `ff_rdata`} into the output buffer. These are the pre-update values.
- FSM:
  - FILL (rows 0–1): read and update the line buffers; no output.
  - The capture of `row`=1, `col`=IMG_WIDTH-1 moves the FSM to STREAM.
  - STREAM (rows 2..IMG_HEIGHT-1): read, update, and emit.
  - The capture of `row`=IMG_HEIGHT-1, `col`=IMG_WIDTH-1 wraps `row`/`col` to 0 and returns to FILL for the next frame.
- Output buffer: 2-entry FIFO (skid).
  - `ff_wrreq` = buffer non-empty AND !`ff_full`.
  - `ff_wdata` = buffer head, held stable while `ff_wrreq` is low.
  - `ff_wdata` is 0 from reset until the first push.
- Read issue:
  - FILL: `ff_rdreq` = !`ff_empty`.
  - STREAM: `ff_rdreq` = !`ff_empty` AND (occupancy + in-flight reads − pop this cycle) < 2.
  - This guarantees that no captured triple is ever dropped while `ff_full` is high.
- Emitted triples per frame = IMG_WIDTH*(IMG_HEIGHT-2). Pixels consumed per frame = IMG_WIDTH*IMG_HEIGHT.
- No arithmetic on the data path; words pass bit-exact.

## Timing
- Reset (`reset`=0, asynchronous) clears:
  - outputs: `ff_rdreq`=0, `ff_wrreq`=0, `ff_wdata`=0;
  - state: FSM=FILL, `col`=0, `row`=0, buffer empty, in-flight=0.
- Reset mid-frame: the partial frame is discarded, buffered triples are dropped, and the next pixel read is treated as row 0, col 0.
- Latency: `ff_rdreq` in cycle t → capture at end of t+1 → `ff_wrreq` high in cycle t+2 if !`ff_full`.
- Steady-state throughput: 1 pixel/cycle in FILL, and 1 triple/cycle in STREAM with upstream non-empty and downstream not full.
- `ff_empty` high: `ff_rdreq` low the same cycle. Counters and FSM are held; the output buffer continues draining.
- `ff_full` high: `ff_wrreq` low. After at most 2 more captures, `ff_rdreq` drops. Nothing is lost; once full deasserts, writes resume from the head.
- Simultaneous push and pop on the output buffer in one cycle: occupancy is unchanged and order is preserved.
- Column wrap and row advance happen on the same capture edge. The FILL→STREAM and STREAM→FILL transitions take effect for the next capture, with no bubble.

## Test plan
Parameters for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=4, DWIDTH=32. Pixel value = row*16 + col.
- Reset check: hold `reset`=0 with `ff_empty`=0 → `ff_rdreq`=0, `ff_wrreq`=0, `ff_wdata`=0.
- Full frame, no stalls:
  - 16 pixels in → exactly 8 writes.
  - First write {0x00, 0x10, 0x20} occurs 10 cycles after the first `ff_rdreq` (8 FILL reads + 2 latency).
  - Last write is {0x13, 0x23, 0x33}.
- Downstream backpressure: hold `ff_full`=1 from the first STREAM capture for 10 cycles → at most 2 triples buffered, `ff_rdreq` low; after release the 8 triples arrive in order with no duplicates.
- Upstream starvation: toggle `ff_empty` every other cycle → `ff_rdreq` never high while `ff_empty`=1; output sequence identical to the no-stall case.
- Back-to-back frames: 32 pixels continuous → 16 writes. The second frame's first triple is {0x00, 0x10, 0x20} and nothing carries over across the frame boundary.
- Mid-frame reset: assert `reset`=0 after 11 pixels, then feed a fresh frame → the output is exactly one clean 8-triple frame.
